fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register for the 16-bit pipelined CPU. It sits directly upstream of the hazard detection unit and consumes its pc_stall/ifid_stall outputs. It owns the PC, drives the instruction-memory address, and presents the fetched instruction to decode. It also handles branch/jump redirects (flush) and a HLT instruction that freezes fetch.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/fetch_pc_reg.sv | 38 +++
 rtl/fetch_stage.sv | 138 +++++++++++++
 tb/tb_fetch_stage.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipelined CPU: instruction encodings and fetch FSM states.
package cpu_pkg;

  localparam logic [15:0] NOP_INSTR  = 16'h0000;
  localparam logic [3:0]  HLT_OPCODE = 4'hF;

  localparam int unsigned OPCODE_MSB = 15;
  localparam int unsigned OPCODE_LSB = 12;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

  function automatic logic is_hlt(input logic [15:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB] == HLT_OPCODE;
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: reset > redirect > hold > increment (wraps modulo 2^ADDR_W).
module fetch_pc_reg #(
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              hold,
  output logic [ADDR_W-1:0] pc
);

  localparam logic [ADDR_W-1:0] PcStep = 1;

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (!hold) begin
      pc_d = pc_q + PcStep;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register, redirect flush and HLT freeze.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pc_stall,
  input  logic               ifid_stall,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0]  ifid_pc,
  output logic               ifid_valid,
  output logic               halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]        stall_cycles,
  output logic [15:0]        fetch_count
`endif
);

  localparam logic [ADDR_W-1:0]  PcStep   = 1;
  localparam logic [INSTR_W-1:0] NopWord  = INSTR_W'(NOP_INSTR);

  fetch_state_e       state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  ifpc_q, ifpc_d;
  logic               valid_q, valid_d;
  logic               pc_hold;
  logic               fetch_load;
  logic [ADDR_W-1:0]  pc;

  fetch_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .hold           (pc_hold),
    .pc             (pc)
  );

  assign imem_addr = pc;

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    ifpc_d     = ifpc_q;
    valid_d    = valid_q;
    pc_hold    = 1'b1;
    fetch_load = 1'b0;
    if (redirect_valid) begin
      // A redirect also cancels a halt: the HLT was fetched on a wrong path.
      state_d = RUN;
      instr_d = NopWord;
      valid_d = 1'b0;
      pc_hold = 1'b0;
    end else if (ifid_stall) begin
      // Holding IF/ID forces the PC to hold too so no fetched word is dropped.
      pc_hold = 1'b1;
    end else if (pc_stall) begin
      instr_d = NopWord;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        RUN: begin
          instr_d    = imem_rdata;
          ifpc_d     = pc + PcStep;
          valid_d    = 1'b1;
          fetch_load = 1'b1;
          if (is_hlt(imem_rdata[15:0])) begin
            state_d = HALT;
          end else begin
            pc_hold = 1'b0;
          end
        end
        HALT: begin
          instr_d = NopWord;
          valid_d = 1'b0;
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      instr_q <= NopWord;
      ifpc_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      valid_q <= valid_d;
    end
  end

  assign ifid_instr = instr_q;
  assign ifid_pc    = ifpc_q;
  assign ifid_valid = valid_q;
  assign halted     = (state_q == HALT);

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] fetch_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      fetch_cnt_q <= '0;
    end else begin
      if ((pc_stall || ifid_stall) && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
      if (fetch_load && !redirect_valid && (fetch_cnt_q != 16'hFFFF)) begin
        fetch_cnt_q <= fetch_cnt_q + 16'd1;
      end
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign fetch_count  = fetch_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, hand sequences and a
// randomized run against a rule-level reference model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pc_stall = 1'b0;
  logic        ifid_stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0;
  logic [15:0] imem_rdata = 16'h0;
  logic [15:0] imem_addr;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc;
  logic        ifid_valid;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] stall_cycles;
  logic [15:0] fetch_count;
`endif

  fetch_stage #(
    .ADDR_W   (16),
    .INSTR_W  (16),
    .RESET_PC (16'h0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_stall       (pc_stall),
    .ifid_stall     (ifid_stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .ifid_instr     (ifid_instr),
    .ifid_pc        (ifid_pc),
    .ifid_valid     (ifid_valid),
    .halted         (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .stall_cycles   (stall_cycles),
    .fetch_count    (fetch_count)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [15:0] m_pc = 16'h0;
  logic [15:0] m_instr = 16'h0;
  logic [15:0] m_ifpc = 16'h0;
  logic        m_valid = 1'b0;
  logic        m_halt = 1'b0;
  int          m_stalls = 0;
  int          m_fetches = 0;

  typedef struct {
    logic        rs, ps, is, rv;
    logic [15:0] rpc;
    logic [15:0] rd;
    logic [15:0] e_addr, e_instr, e_pc;
    logic        e_valid, e_halt;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory contents never decode as HLT (bit 15 is always clear).
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {1'b0, a[14:0]} ^ 16'h1234;
  endfunction

  task automatic model_step(input logic rs, input logic ps, input logic is, input logic rv,
                            input logic [15:0] rpc, input logic [15:0] rd);
    if (!rs && (ps || is)) m_stalls = (m_stalls < 65535) ? m_stalls + 1 : 65535;
    if (rs) begin
      m_pc = 16'h0; m_instr = 16'h0; m_ifpc = 16'h0; m_valid = 1'b0; m_halt = 1'b0;
      m_stalls = 0; m_fetches = 0;
    end else if (rv) begin
      m_pc = rpc; m_instr = 16'h0; m_valid = 1'b0; m_halt = 1'b0;
    end else if (is) begin
      // everything holds
    end else if (ps || m_halt) begin
      m_instr = 16'h0; m_valid = 1'b0;
    end else begin
      m_instr = rd; m_ifpc = m_pc + 16'd1; m_valid = 1'b1;
      m_fetches = (m_fetches < 65535) ? m_fetches + 1 : 65535;
      if (rd[15:12] == 4'hF) m_halt = 1'b1;
      else m_pc = m_pc + 16'd1;
    end
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".imem_addr"}, imem_addr, m_pc);
    check({tag, ".ifid_instr"}, ifid_instr, m_instr);
    check({tag, ".ifid_valid"}, ifid_valid, m_valid);
    check({tag, ".halted"}, halted, m_halt);
    if (m_valid) check({tag, ".ifid_pc"}, ifid_pc, m_ifpc);
`ifdef FETCH_PERF_CNT_EN
    check({tag, ".stall_cycles"}, stall_cycles, m_stalls);
    check({tag, ".fetch_count"}, fetch_count, m_fetches);
`endif
  endtask

  task automatic drive(input logic rs, input logic ps, input logic is, input logic rv,
                       input logic [15:0] rpc, input logic [15:0] rd);
    rst = rs; pc_stall = ps; ifid_stall = is; redirect_valid = rv;
    redirect_pc = rpc; imem_rdata = rd;
  endtask

  task automatic step(input string tag, input logic rs, input logic ps, input logic is,
                      input logic rv, input logic [15:0] rpc, input bit force_rd,
                      input logic [15:0] rd);
    logic [15:0] data;
    @(negedge clk);
    data = force_rd ? rd : mem_word(m_pc);
    drive(rs, ps, is, rv, rpc, data);
    @(posedge clk);
    model_step(rs, ps, is, rv, rpc, data);
    #1;
    compare_model(tag);
  endtask

  initial begin
    //          rs    ps    is    rv    rpc       rd        addr      instr     ifpc      v     h
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h1234, 16'h0001, 16'h1234, 16'h0001, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h1234, 16'h0002, 16'h1234, 16'h0002, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h1234, 16'h0003, 16'h1234, 16'h0003, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0040, 16'h1234, 16'h0040, 16'h0000, 16'h0000, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'hF000, 16'h0040, 16'hF000, 16'h0041, 1'b1, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h1234, 16'h0040, 16'h0000, 16'h0000, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h1234, 16'h0040, 16'h0000, 16'h0000, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0010, 16'h1234, 16'h0010, 16'h0000, 16'h0000, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h5555, 16'h0011, 16'h5555, 16'h0011, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h6666, 16'h0011, 16'h5555, 16'h0011, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h7777, 16'h0011, 16'h0000, 16'h0000, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h1234, 16'h0001, 16'h1234, 16'h0001, 1'b1, 1'b0};

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(tbl[i].rs, tbl[i].ps, tbl[i].is, tbl[i].rv, tbl[i].rpc, tbl[i].rd);
      @(posedge clk);
      model_step(tbl[i].rs, tbl[i].ps, tbl[i].is, tbl[i].rv, tbl[i].rpc, tbl[i].rd);
      #1;
      check($sformatf("vec%0d.imem_addr", i), imem_addr, tbl[i].e_addr);
      check($sformatf("vec%0d.ifid_instr", i), ifid_instr, tbl[i].e_instr);
      check($sformatf("vec%0d.ifid_valid", i), ifid_valid, tbl[i].e_valid);
      check($sformatf("vec%0d.halted", i), halted, tbl[i].e_halt);
      if (tbl[i].e_valid) check($sformatf("vec%0d.ifid_pc", i), ifid_pc, tbl[i].e_pc);
    end

    // Stall at pc=5: IF/ID keeps the word from 4, fetch resumes at 5.
    step("stl_redir", 1'b0, 1'b0, 1'b0, 1'b1, 16'h0004, 1'b0, 16'h0);
    step("stl_fetch4", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    for (int i = 0; i < 3; i++) step("stl_hold", 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
    check("stl_held_instr", ifid_instr, mem_word(16'h0004));
    step("stl_resume", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    check("stl_resume_instr", ifid_instr, mem_word(16'h0005));

    // HLT at 7, bubbles while halted, redirect to 0x10 restarts fetch.
    step("hlt_redir", 1'b0, 1'b0, 1'b0, 1'b1, 16'h0007, 1'b0, 16'h0);
    step("hlt_fetch", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'hF000);
    step("hlt_bub1", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    step("hlt_bub2", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    check("hlt_pc_frozen", imem_addr, 16'h0007);
    step("hlt_exit", 1'b0, 1'b0, 1'b0, 1'b1, 16'h0010, 1'b0, 16'h0);
    step("hlt_refetch", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);

    // PC wrap at 0xFFFF, then reset during an active stall.
    step("wrap_redir", 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b0, 16'h0);
    step("wrap_fetch", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    check("wrap_ifid_pc", ifid_pc, 16'h0000);
    step("rst_stall_a", 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
    step("rst_stall_b", 1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0);

    // Randomized run against the reference model.
    for (int i = 0; i < 3000; i++) begin
      logic rs, ps, is, rv, hf;
      logic [15:0] rpc;
      rs  = ($urandom_range(63) == 0);
      rv  = ($urandom_range(15) == 0);
      ps  = ($urandom_range(3) == 0);
      is  = ($urandom_range(3) == 0);
      hf  = ($urandom_range(24) == 0);
      rpc = ($urandom_range(3) == 0) ? 16'hFFFE : 16'($urandom);
      step("rand", rs, ps, is, rv, rpc, hf, {4'hF, 12'($urandom)});
    end

`ifdef FETCH_PERF_CNT_EN
    step("perf_rst", 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    for (int i = 0; i < 4; i++) step("perf_stall", 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    for (int i = 0; i < 10; i++) step("perf_fetch", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    check("perf_stall_cycles", stall_cycles, 16'd4);
    check("perf_fetch_count", fetch_count, 16'd10);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0);
    repeat (70000) @(posedge clk);
    #1;
    check("perf_stall_sat", stall_cycles, 16'hFFFF);
    check("perf_fetch_held", fetch_count, 16'd10);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
